// File: rtl/sound_generator_psg_if.sv
// Write-bus interface for the PSG: active-low strobe plus data byte from the VIA slow bus.
interface sound_generator_psg_if;
  logic       nWE;
  logic [7:0] DATA;

  modport master (output nWE, output DATA);
  modport slave  (input  nWE, input  DATA);
endinterface

// File: rtl/sound_generator_psg.sv
// SN76489-compatible PSG: three square-wave tones, one LFSR noise channel, 4-bit attenuators,
// amplitude mixer and 8-bit PWM output. Tone/noise/tick widths are parametrised.
module sound_generator_psg #(
  parameter int unsigned           TONE_W     = 10,
  parameter int unsigned           NOISE_W    = 15,
  parameter logic [NOISE_W-1:0]    NOISE_TAPS = 15'h0003,
  parameter int unsigned           CLK_DIV    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  sound_generator_psg_if.slave   bus,
  output logic                   PWM,
  output logic [7:0]             SAMPLE
);

  localparam logic [NOISE_W-1:0] SEED = {1'b1, {(NOISE_W-1){1'b0}}};

  logic [3:0]        att       [4];
  logic [TONE_W-1:0] period    [4];
  logic [TONE_W-1:0] tone_cnt  [3];
  logic [2:0]        tone_out;
  logic [2:0]        latch_sel;
  logic [2:0]        noise_ctrl;
  logic [NOISE_W-1:0] lfsr;
  logic [7:0]        div_cnt;
  logic [5:0]        noise_cnt;
  logic              tone2_prev;
  logic              nwe_prev;
  logic [7:0]        pwm_cnt;
  logic [7:0]        mix;

  logic write_en, tick, reseed, noise_shift, feedback;

  function automatic logic [5:0] amp(input logic [3:0] a);
    case (a)
      4'h0: amp = 6'd63; 4'h1: amp = 6'd50; 4'h2: amp = 6'd40; 4'h3: amp = 6'd32;
      4'h4: amp = 6'd25; 4'h5: amp = 6'd20; 4'h6: amp = 6'd16; 4'h7: amp = 6'd13;
      4'h8: amp = 6'd10; 4'h9: amp = 6'd8;  4'hA: amp = 6'd6;  4'hB: amp = 6'd5;
      4'hC: amp = 6'd4;  4'hD: amp = 6'd3;  4'hE: amp = 6'd2;  default: amp = 6'd0;
    endcase
  endfunction

  always_comb begin
    write_en    = clk_en && !bus.nWE && nwe_prev;
    tick        = clk_en && (div_cnt == 8'(CLK_DIV - 1));
    reseed      = write_en && ((bus.DATA[7] && bus.DATA[6:4] == 3'b110) ||
                               (!bus.DATA[7] && latch_sel == 3'b110));
    noise_shift = (noise_ctrl[1:0] == 2'b11) ? (clk_en && tone_out[2] && !tone2_prev)
                                             : (tick && noise_cnt == '0);
    feedback    = noise_ctrl[2] ? ^(lfsr & NOISE_TAPS) : lfsr[0];
  end

  // Register file: latch byte selects and writes the low nibble; data byte reuses the latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_sel  <= '0;
      noise_ctrl <= '0;
      nwe_prev   <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        att[i]    <= '1;
        period[i] <= '0;
      end
    end else begin
      if (clk_en) nwe_prev <= bus.nWE;
      if (write_en) begin
        if (bus.DATA[7]) begin
          latch_sel <= bus.DATA[6:4];
          if (bus.DATA[4])              att[bus.DATA[6:5]] <= bus.DATA[3:0];
          else if (bus.DATA[6:5] == 2'd3) noise_ctrl <= bus.DATA[2:0];
          else                          period[bus.DATA[6:5]][3:0] <= bus.DATA[3:0];
        end else begin
          if (latch_sel[0])                att[latch_sel[2:1]] <= bus.DATA[3:0];
          else if (latch_sel[2:1] == 2'd3) noise_ctrl <= bus.DATA[2:0];
          else
            for (int unsigned b = 4; b < TONE_W; b++)
              period[latch_sel[2:1]][b] <= bus.DATA[b-4];
        end
      end
    end
  end

  // Counters reload with period-1 so the output toggles every `period` ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      noise_cnt  <= '0;
      tone_out   <= '1;
      tone2_prev <= 1'b1;
      lfsr       <= SEED;
      for (int unsigned i = 0; i < 3; i++) tone_cnt[i] <= '0;
    end else begin
      if (clk_en) begin
        div_cnt    <= tick ? '0 : div_cnt + 8'd1;
        tone2_prev <= tone_out[2];
      end
      if (tick) begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (period[i] < TONE_W'(2)) begin
            tone_out[i] <= 1'b1;
            tone_cnt[i] <= '0;
          end else if (tone_cnt[i] == '0) begin
            tone_cnt[i] <= period[i] - 1'b1;
            tone_out[i] <= ~tone_out[i];
          end else begin
            tone_cnt[i] <= tone_cnt[i] - 1'b1;
          end
        end
        if (noise_ctrl[1:0] != 2'b11) begin
          if (noise_cnt == '0)
            case (noise_ctrl[1:0])
              2'b00:   noise_cnt <= 6'd15;
              2'b01:   noise_cnt <= 6'd31;
              default: noise_cnt <= 6'd63;
            endcase
          else
            noise_cnt <= noise_cnt - 6'd1;
        end
      end
      if (reseed)           lfsr <= SEED;
      else if (noise_shift) lfsr <= {feedback, lfsr[NOISE_W-1:1]};
    end
  end

  always_comb begin
    mix = '0;
    for (int unsigned i = 0; i < 3; i++)
      if (tone_out[i]) mix = mix + 8'(amp(att[i]));
    if (lfsr[0]) mix = mix + 8'(amp(att[3]));
  end

  // PWM runs on every clk; SAMPLE only updates at the counter wrap to keep each period glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      SAMPLE  <= '0;
      PWM     <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'hFF) SAMPLE <= mix;
      PWM <= (pwm_cnt < SAMPLE);
    end
  end

endmodule
